// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding, ACK levels and address helper for the I2C register target.
package i2c_pkg;
   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, ACK_DEV, ADDR_HI, ACK_AH, ADDR_LO, ACK_AL,
      WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP
   } state_e;
   localparam logic       ACK            = 1'b0;
   localparam logic       NACK           = 1'b1;
   localparam logic [6:0] DEF_SLAVE_ADDR = 7'h2b;
   // 8-bit register maps wrap inside the low byte
   function automatic logic [15:0] addr_inc(input logic [15:0] a, input logic bit_ctrl);
      return bit_ctrl ? a + 16'd1 : {8'h00, a[7:0] + 8'd1};
   endfunction
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchroniser, FILTER_LEN-sample glitch filter and single-cycle edge pulses.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d, rise_q, rise_d, fall_q, fall_d;
   always_comb begin
      sync_d  = {sync_q[0], din};
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[1] != level_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CW'(FILTER_LEN)) begin
            level_d = sync_q[1];
            cnt_d   = '0;
         end
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end
   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
endmodule

// File: rtl/i2c_slave_reg.sv
// i2c_slave_reg: I2C target turning write/read transactions into single-cycle register-bus strobes.
module i2c_slave_reg
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
   parameter logic       BIT_CTRL   = 1'b1,
   parameter int         FILTER_LEN = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl,
   inout  wire         sda,
   output logic        reg_wr,
   output logic        reg_rd,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wdata,
   input  logic [7:0]  reg_rdata,
   output logic        busy
);
   logic        scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
   logic        start, stop, shifting, byte_done, dev_hit;
   logic [7:0]  byte_in;
   state_e      state_q, state_d, ack_next;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d, reg_wdata_q, reg_wdata_d, rd_byte_q, rd_byte_d;
   logic [15:0] reg_addr_q, reg_addr_d;
   logic [1:0]  rd_dly_q, rd_dly_d;
   logic        rw_q, rw_d, reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, busy_q, busy_d, sda_oe_q, sda_oe_d;
   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
      .clk(clk), .rst(rst), .din(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );
   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
      .clk(clk), .rst(rst), .din(sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );
   assign start     = sda_fall & scl_lvl;
   assign stop      = sda_rise & scl_lvl;
   assign byte_in   = {shift_q[6:0], sda_lvl};
   assign shifting  = state_q inside {DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA};
   assign byte_done = shifting && scl_rise && bit_cnt_q == 4'd7;
   assign dev_hit   = byte_in[7:1] == SLAVE_ADDR;
   assign ack_next  = state_q == ACK_DEV ? (rw_q ? RD_DATA : BIT_CTRL ? ADDR_HI : ADDR_LO) :
                      state_q == ACK_AH ? ADDR_LO : WR_DATA;
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rw_d        = rw_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_d    = 1'b0;
      reg_rd_d    = 1'b0;
      busy_d      = busy_q;
      sda_oe_d    = sda_oe_q;
      rd_dly_d    = {rd_dly_q[0], reg_rd_q};
      rd_byte_d   = rd_dly_q[1] ? reg_rdata : rd_byte_q;
      if (start) begin
         state_d   = DEV_ADDR;
         bit_cnt_d = '0;
         busy_d    = 1'b1;
         sda_oe_d  = 1'b0;
      end else if (stop) begin
         state_d  = IDLE;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else begin
         if (shifting && scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
         case (state_q)
            DEV_ADDR: if (byte_done) begin
               state_d  = dev_hit ? ACK_DEV : WAIT_STOP;
               rw_d     = byte_in[0];
               reg_rd_d = dev_hit && byte_in[0];
            end
            ADDR_HI: if (byte_done) begin
               reg_addr_d[15:8] = byte_in;
               state_d          = ACK_AH;
            end
            ADDR_LO: if (byte_done) begin
               reg_addr_d = {BIT_CTRL ? reg_addr_q[15:8] : 8'h00, byte_in};
               state_d    = ACK_AL;
            end
            WR_DATA: if (byte_done) begin
               reg_wdata_d = byte_in;
               reg_wr_d    = 1'b1;
               state_d     = ACK_WR;
            end
            // first fall starts the ACK pulse, second fall ends it
            ACK_DEV, ACK_AH, ACK_AL, ACK_WR: if (scl_fall) begin
               sda_oe_d  = ~sda_oe_q;
               bit_cnt_d = '0;
               if (sda_oe_q) begin
                  state_d = ack_next;
                  if (state_q == ACK_WR) reg_addr_d = addr_inc(reg_addr_q, BIT_CTRL);
                  if (state_q == ACK_DEV && rw_q) begin
                     sda_oe_d  = ~rd_byte_q[7];
                     bit_cnt_d = 4'd1;
                  end
               end
            end
            RD_DATA: if (scl_fall) begin
               if (bit_cnt_q[3]) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = RD_ACK;
               end else begin
                  sda_oe_d  = ~rd_byte_q[3'd7 - bit_cnt_q[2:0]];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            // bit_cnt[0] marks an ACKed byte awaiting the fall that places its first bit
            RD_ACK: if (scl_rise && !bit_cnt_q[0]) begin
               if (sda_lvl == ACK) begin
                  reg_addr_d = addr_inc(reg_addr_q, BIT_CTRL);
                  reg_rd_d   = 1'b1;
                  bit_cnt_d  = 4'd1;
               end else begin
                  state_d = WAIT_STOP;
               end
            end else if (scl_fall && bit_cnt_q[0]) begin
               sda_oe_d = ~rd_byte_q[7];
               state_d  = RD_DATA;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rw_q        <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         busy_q      <= 1'b0;
         sda_oe_q    <= 1'b0;
         rd_dly_q    <= '0;
         rd_byte_q   <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_q    <= reg_wr_d;
         reg_rd_q    <= reg_rd_d;
         busy_q      <= busy_d;
         sda_oe_q    <= sda_oe_d;
         rd_dly_q    <= rd_dly_d;
         rd_byte_q   <= rd_byte_d;
      end
   end
   assign sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign reg_wr    = reg_wr_q;
   assign reg_rd    = reg_rd_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign busy      = busy_q;
endmodule

// File: doc/i2c_slave_reg.md
Name: i2c_slave_reg

Overview:
I2C target (responder) with a 7-bit device address, 16-bit register address and 8-bit data. It decodes write and read transactions from an external I2C initiator and converts them into a single-cycle register-bus handshake toward an internal register bank. It is the counterpart of the team's I2C initiator driver. It is used for on-board loopback verification and for exposing FPGA status and control registers over I2C.

Parameters:
SLAVE_ADDR, 7'h2b, 7-bit device address to respond to
BIT_CTRL, 1'b1, register-address width: 0 = 8-bit, 1 = 16-bit (high byte first)
FILTER_LEN, 3, consecutive equal samples of synchronised SCL/SDA required to accept a level change

Ports:
clk  input  1  system clock; must be at least 20x SCL
rst  input  1  asynchronous, active-high reset
scl  input  1  I2C clock from initiator; no clock stretching
sda  inout  1  I2C data, open-drain: drives 1'b0 when sda_oe, otherwise 1'bz
reg_wr  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read request
reg_addr  output  16  register address for reg_wr/reg_rd
reg_wdata  output  8  write data, valid with reg_wr
reg_rdata  input  8  read data; must be valid 2 clk after reg_rd and held until the next reg_rd
busy  output  1  high from accepted START to STOP

Behaviour:
- Reset values: reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, sda released, FSM=IDLE.
- Input conditioning: 2-FF synchronisers on scl and sda, followed by a FILTER_LEN glitch filter. SCL rise/fall are single-cycle pulses derived from the filtered level.
- START = filtered SDA falls while SCL is high. STOP = SDA rises while SCL is high. A START in any state, including a repeated START, goes to DEV_ADDR and sets busy. A STOP in any state goes to IDLE, clears busy and releases sda.
- Bit sampling: data bits are sampled on SCL rise, MSB first. The target changes sda only on SCL fall.
- FSM states: IDLE, DEV_ADDR, ACK_DEV, ADDR_HI, ACK_AH, ADDR_LO, ACK_AL, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP.
- DEV_ADDR: shift 8 bits. If the upper 7 bits equal SLAVE_ADDR, go to ACK_DEV. Otherwise go to WAIT_STOP with no ACK.
- ACK_DEV: drive SDA low from the SCL fall after bit 8 until the next SCL fall.
  - R/W=0: go to ADDR_HI (BIT_CTRL=1) or ADDR_LO (BIT_CTRL=0).
  - R/W=1: pulse reg_rd with the current reg_addr at entry to ACK_DEV, latch reg_rdata 2 clk later, then go to RD_DATA.
- ADDR_HI/ADDR_LO: shift 8 bits into reg_addr[15:8]/[7:0] and ACK each byte. For BIT_CTRL=0, reg_addr[15:8] is forced to 0. After ACK_AL go to WR_DATA.
- WR_DATA: shift 8 bits. On the SCL rise of bit 8, load reg_wdata and pulse reg_wr for exactly 1 clk with the current reg_addr. ACK in ACK_WR, then increment reg_addr and return to WR_DATA.
- RD_DATA: drive the latched byte MSB first. Bit 7 is placed at the SCL fall ending ACK_DEV or RD_ACK; the following bits are placed on subsequent falls. After the 8th bit, release sda and go to RD_ACK.
- RD_ACK: sample the initiator ACK on SCL rise.
  - ACK (SDA=0): increment reg_addr, pulse reg_rd, latch the new byte, go to RD_DATA.
  - NACK: go to WAIT_STOP.
- Address increment is 16-bit and wraps 0xFFFF to 0x0000. With BIT_CTRL=0 it wraps 0x00FF to 0x0000.
- A repeated START after an address-write phase keeps reg_addr, which enables a combined write-address/read transaction.
- Async rst mid-transfer: all outputs return immediately to their reset values and sda is released. The next transaction must begin with a START.
- A STOP mid-byte discards the partial byte and produces no reg_wr.
- Simultaneous START detection and SCL edge are impossible by protocol; START has priority.

Decomposition:
- Shared package i2c_pkg holds the FSM state encoding, the ACK/NACK constants and the default SLAVE_ADDR 7'h2b.
- One natural sub-module: i2c_line_filter, instantiated for both scl and sda. It contains the synchroniser, the glitch filter and the rise/fall pulse outputs.

Test Plan:
- Write 0x56 (addr 0x2B, W), reg 0x1234, data 0xA5, STOP -> 4 ACKs; one reg_wr with reg_addr=0x1234, reg_wdata=0xA5; busy low after STOP.
- Burst write from reg 0xFFFE, data 0x11, 0x22, 0x33 -> reg_wr at 0xFFFE, 0xFFFF, 0x0000 with those data; no extra strobes.
- Write reg 0x0010, repeated START, 0x57 (R), bank returns 0x3C then 0x4D, initiator ACKs the first byte and NACKs the second -> SDA carries 0x3C then 0x4D; reg_rd at 0x0010 and 0x0011; sda released after the NACK.
- Device address 0x2C (0x58) write -> no ACK (SDA high on 9th clock); no reg_wr/reg_rd; idle until STOP, then the next 0x56 transaction is accepted.
- Assert rst during the 4th bit of the data byte, release it, then send a full write of 0x77 to 0x0001 -> no strobe from the aborted transfer; one reg_wr with 0x0001/0x77.
- 1-clk glitch on SCL (FILTER_LEN=3) during the data phase, plus BIT_CTRL=0 write of reg 0x80 data 0xFF -> no spurious bit shift; reg_wr with reg_addr=0x0080, reg_wdata=0xFF.
